// File: rtl/mask_morph_erode.sv
// mask_morph_erode
//   3x3 binary erosion of a foreground/movement mask carried on an AXI-Stream
//   video bus, one pixel per beat. It removes isolated noise pixels ahead of the
//   blob/bbox analysis. Two 1-bit line buffers plus two 3-bit column registers
//   form the window. The output geometry equals the input geometry. The window
//   centre lags the current input pixel by one row and one column.
//
// Ports
//   clk, aresetn                    pixel clock, asynchronous active-low reset
//   s_axis_tdata/tvalid/tready      input mask pixel (mask bit = |tdata)
//   s_axis_tuser/tlast              start of frame / end of line
//   m_axis_tdata/tvalid/tready      eroded pixel: all ones or all zeros
//   m_axis_tuser/tlast              copied through from the input beat
//   erode_en                        1 = erode, 0 = bypass; latched on each SOF beat
//   line_err                        sticky: tlast at the wrong column
//   frame_err                       sticky: beats after a complete frame, or SOF mid-frame
//   err_clr                         synchronous clear of both error flags
//   fg_count, fg_count_valid        foreground pixel total per frame
//                                   (only present with MORPH_FG_COUNT_EN)
//
// Build option: define MORPH_FG_COUNT_EN to add the per-frame foreground counter.
module mask_morph_erode #(
    parameter int TDATA_WIDTH = 24,
    parameter int IMG_WIDTH   = 1280,
    parameter int IMG_HEIGHT  = 720
) (
    input  logic                   clk,
    input  logic                   aresetn,
    input  logic [TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic                   s_axis_tvalid,
    output logic                   s_axis_tready,
    input  logic                   s_axis_tuser,
    input  logic                   s_axis_tlast,
    output logic [TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic                   m_axis_tuser,
    output logic                   m_axis_tlast,
    input  logic                   erode_en,
    output logic                   line_err,
    output logic                   frame_err,
`ifdef MORPH_FG_COUNT_EN
    output logic [$clog2(IMG_WIDTH*IMG_HEIGHT+1)-1:0] fg_count,
    output logic                   fg_count_valid,
`endif
    input  logic                   err_clr
);
    localparam int X_W = $clog2(IMG_WIDTH);
    localparam int Y_W = $clog2(IMG_HEIGHT);
    localparam logic [X_W-1:0] X_LAST = X_W'(IMG_WIDTH - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(IMG_HEIGHT - 1);
    localparam logic [X_W-1:0] X_TWO  = X_W'(2);
    localparam logic [Y_W-1:0] Y_TWO  = Y_W'(2);

    typedef enum logic [0:0] {WAIT_SOF, ACTIVE} state_t;
    state_t state_q, state_d;

    logic [X_W-1:0]       x_q, ex;
    logic [Y_W-1:0]       y_q, ey;
    logic [IMG_WIDTH-1:0] lb0_q, lb1_q;
    logic [2:0]           col_p0, col_p1, col_p2;
    logic                 erode_q, seen_frame_q;
    logic                 accept, in_bit, proc, stray, restart;
    logic                 row_end, frame_end, mode, win_and, out_bit;

    assign s_axis_tready = m_axis_tready | ~m_axis_tvalid;
    assign accept        = s_axis_tvalid & s_axis_tready;
    assign in_bit        = |s_axis_tdata;

    // ex/ey are the coordinates of the beat being accepted.
    // An SOF beat always sits at (0,0), including when it restarts a frame.
    always_comb begin
        state_d = state_q;
        proc    = 1'b0;
        stray   = 1'b0;
        restart = 1'b0;
        ex      = x_q;
        ey      = y_q;
        case (state_q)
            WAIT_SOF: begin
                if (accept) begin
                    if (s_axis_tuser) begin
                        proc = 1'b1;
                        ex   = '0;
                        ey   = '0;
                    end else begin
                        // Beats before the very first SOF are not an error.
                        stray = seen_frame_q;
                    end
                end
            end
            ACTIVE: begin
                if (accept) begin
                    proc = 1'b1;
                    if (s_axis_tuser) begin
                        restart = (x_q != '0) || (y_q != '0);
                        ex      = '0;
                        ey      = '0;
                    end
                end
            end
            default: state_d = WAIT_SOF;
        endcase
        row_end   = s_axis_tlast | (ex == X_LAST);
        frame_end = proc & row_end & (ey == Y_LAST);
        if (proc) begin
            state_d = frame_end ? WAIT_SOF : ACTIVE;
        end
    end

    // Stage p0: current column {row y-2, row y-1, row y}. The buffers are read before they are written.
    assign col_p0  = {lb1_q[ex], lb0_q[ex], in_bit};
    assign win_and = &{col_p0, col_p1, col_p2};
    assign mode    = s_axis_tuser ? erode_en : erode_q;
    // The first two rows and columns have no complete window.
    // They are forced to background, which also masks stale column registers at x = 0 and x = 1.
    assign out_bit = mode ? (win_and & (ex >= X_TWO) & (ey >= Y_TWO)) : in_bit;

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q      <= WAIT_SOF;
            x_q          <= '0;
            y_q          <= '0;
            erode_q      <= 1'b0;
            seen_frame_q <= 1'b0;
            line_err     <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (proc) begin
                if (s_axis_tuser) begin
                    erode_q <= erode_en;
                end
                if (frame_end) begin
                    x_q          <= '0;
                    y_q          <= '0;
                    seen_frame_q <= 1'b1;
                end else if (row_end) begin
                    x_q <= '0;
                    y_q <= ey + 1'b1;
                end else begin
                    x_q <= ex + 1'b1;
                    y_q <= ey;
                end
            end
            // A newly detected error takes priority over err_clr in the same cycle.
            line_err  <= (proc & (s_axis_tlast ^ (ex == X_LAST))) | (line_err & ~err_clr);
            frame_err <= stray | restart | (frame_err & ~err_clr);
        end
    end

    // Stages p1/p2: column registers holding x-1 and x-2
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            lb0_q  <= '0;
            lb1_q  <= '0;
            col_p1 <= '0;
            col_p2 <= '0;
        end else if (proc) begin
            lb1_q[ex] <= lb0_q[ex];
            lb0_q[ex] <= in_bit;
            col_p1    <= col_p0;
            col_p2    <= col_p1;
        end
    end

    // Output register: one output beat per processed input beat
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tuser  <= 1'b0;
            m_axis_tlast  <= 1'b0;
        end else if (proc) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= {TDATA_WIDTH{out_bit}};
            m_axis_tuser  <= s_axis_tuser;
            m_axis_tlast  <= s_axis_tlast;
        end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
        end
    end

`ifdef MORPH_FG_COUNT_EN
    localparam int CNT_W = $clog2(IMG_WIDTH*IMG_HEIGHT+1);
    logic [CNT_W-1:0] fg_acc_q, fg_acc_d;

    // Restarting on the SOF beat includes that beat's own output bit.
    assign fg_acc_d = (s_axis_tuser ? '0 : fg_acc_q) + CNT_W'(out_bit);

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            fg_acc_q       <= '0;
            fg_count       <= '0;
            fg_count_valid <= 1'b0;
        end else begin
            fg_count_valid <= proc & frame_end;
            if (proc) begin
                fg_acc_q <= fg_acc_d;
                if (frame_end) begin
                    fg_count <= fg_acc_d;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_mask_morph_erode.sv
// Directed/random bench for mask_morph_erode with an 8x6 image.
// Expected pixels come from a 2-D image array and a window-AND reference.
module tb_mask_morph_erode;
    localparam int DW = 24;
    localparam int W  = 8;
    localparam int H  = 6;
    localparam int CW = $clog2(W*H+1);

    logic          clk = 1'b0;
    logic          aresetn = 1'b0;
    logic [DW-1:0] s_axis_tdata = '0;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tuser = 1'b0;
    logic          s_axis_tlast = 1'b0;
    logic          s_axis_tready;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid, m_axis_tuser, m_axis_tlast;
    logic          m_axis_tready = 1'b1;
    logic          erode_en = 1'b1;
    logic          err_clr = 1'b0;
    logic          line_err, frame_err;
`ifdef MORPH_FG_COUNT_EN
    logic [CW-1:0] fg_count;
    logic          fg_count_valid;
`endif

    int            total = 0;
    int            bad = 0;
    int            base = 0;
    bit            rand_rdy = 1'b0;
    int            gap_pct = 0;
    bit            img [H][W];
    logic [DW+1:0] outq [$];
    logic [DW+1:0] expq [$];

    mask_morph_erode #(.TDATA_WIDTH(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk(clk), .aresetn(aresetn),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .s_axis_tuser(s_axis_tuser), .s_axis_tlast(s_axis_tlast),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tuser(m_axis_tuser), .m_axis_tlast(m_axis_tlast),
        .erode_en(erode_en), .line_err(line_err), .frame_err(frame_err),
`ifdef MORPH_FG_COUNT_EN
        .fg_count(fg_count), .fg_count_valid(fg_count_valid),
`endif
        .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    // Output monitor: a beat transfers at the next posedge if valid&ready hold at negedge.
    always @(negedge clk) begin
        if (aresetn && m_axis_tvalid && m_axis_tready)
            outq.push_back({m_axis_tuser, m_axis_tlast, m_axis_tdata});
    end

`ifdef MORPH_FG_COUNT_EN
    int            fg_pulses = 0;
    int            fg_wide = 0;
    logic          fg_prev = 1'b0;
    logic [CW-1:0] fg_last = '0;
    always @(negedge clk) begin
        if (fg_count_valid) begin
            fg_pulses++;
            fg_last = fg_count;
            if (fg_prev) fg_wide++;
        end
        fg_prev = fg_count_valid;
    end
`endif

    initial begin
        forever begin
            @(posedge clk);
            #1;
            m_axis_tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [DW-1:0] d, input logic u, input logic l);
        int n = 0;
        while (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
            s_axis_tvalid = 1'b0;
            @(posedge clk);
            #1;
        end
        s_axis_tdata  = d;
        s_axis_tuser  = u;
        s_axis_tlast  = l;
        s_axis_tvalid = 1'b1;
        forever begin
            @(negedge clk);
            if (s_axis_tready || n > 200) break;
            n++;
        end
        if (n > 200) chk("send_stall", 1, 0);
        @(posedge clk);
        #1;
        s_axis_tvalid = 1'b0;
    endtask

    // erode_en is scrambled after the SOF beat; only the SOF value may matter.
    task automatic send_frame(input bit er);
        erode_en = er;
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) begin
                send({DW{img[y][x]}}, x == 0 && y == 0, x == W-1);
                if (x == 0 && y == 0) erode_en = 1'($urandom_range(0, 1));
            end
    endtask

    function automatic bit model_px(input bit er, input int x, input int y);
        if (!er) return img[y][x];
        if (x < 2 || y < 2) return 1'b0;
        for (int dy = 0; dy < 3; dy++)
            for (int dx = 0; dx < 3; dx++)
                if (!img[y-dy][x-dx]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic build_model(input bit er);
        expq.delete();
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                expq.push_back({1'(x == 0 && y == 0), 1'(x == W-1), {DW{model_px(er, x, y)}}});
    endtask

    task automatic wait_out(input int n);
        int c = 0;
        while (outq.size() < base + n && c < 1000) begin
            @(posedge clk);
            c++;
        end
        repeat (10) @(posedge clk);
        #1;
    endtask

    task automatic check_exp(input string tag, input bit full);
        int ones = 0;
        wait_out(expq.size());
        chk({tag, "_beats"}, outq.size() - base, expq.size());
        for (int i = 0; i < expq.size(); i++) begin
            if (expq[i][0]) ones++;
            if (base + i < outq.size())
                chk($sformatf("%s[%0d]", tag, i), outq[base+i], expq[i]);
        end
        base = outq.size();
`ifdef MORPH_FG_COUNT_EN
        if (full) begin
            chk({tag, "_fg_count"}, fg_last, ones);
            chk({tag, "_fg_pulses"}, fg_pulses, 1);
            chk({tag, "_fg_wide"}, fg_wide, 0);
            fg_pulses = 0;
        end
`else
        if (full && ones < 0) chk({tag, "_ones"}, ones, 0);
`endif
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tvalid", m_axis_tvalid, 0);
        chk("rst_tdata", m_axis_tdata, 0);
        chk("rst_tuser", m_axis_tuser, 0);
        chk("rst_tlast", m_axis_tlast, 0);
        chk("rst_line_err", line_err, 0);
        chk("rst_frame_err", frame_err, 0);
        chk("rst_tready", s_axis_tready, 1);
`ifdef MORPH_FG_COUNT_EN
        chk("rst_fg_count", fg_count, 0);
        chk("rst_fg_valid", fg_count_valid, 0);
`endif
        aresetn = 1'b1;
        @(posedge clk);
        #1;

        // Beats before the first SOF are discarded silently.
        for (int i = 0; i < 10; i++)
            send(DW'($urandom), 1'b0, 1'($urandom_range(0, 1)));
        repeat (5) @(posedge clk);
        #1;
        chk("presof_no_out", outq.size(), 0);
        chk("presof_frame_err", frame_err, 0);

        // All-ones frame with erosion.
        for (int y = 0; y < H; y++) for (int x = 0; x < W; x++) img[y][x] = 1'b1;
        send_frame(1'b1);
        build_model(1'b1);
        check_exp("ones_erode", 1'b1);
`ifdef MORPH_FG_COUNT_EN
        chk("ones_fg_24", fg_last, 24);
`endif
        chk("ones_line_err", line_err, 0);
        chk("ones_frame_err", frame_err, 0);

        // Isolated pixel: eroded away, bypass passes it through.
        for (int y = 0; y < H; y++) for (int x = 0; x < W; x++) img[y][x] = 1'b0;
        img[3][4] = 1'b1;
        send_frame(1'b1);
        build_model(1'b1);
        check_exp("iso_erode", 1'b1);
        send_frame(1'b0);
        build_model(1'b0);
        chk("iso_model_px28", expq[28][0], 1);
        check_exp("iso_bypass", 1'b1);

        // Random frames: ready=1 first, then random backpressure with input gaps.
        for (int k = 0; k < 3; k++) begin
            bit er;
            er = (k != 2);
            for (int y = 0; y < H; y++)
                for (int x = 0; x < W; x++) img[y][x] = ($urandom_range(0, 99) < 80);
            build_model(er);
            rand_rdy = 1'b0;
            gap_pct  = 0;
            send_frame(er);
            check_exp($sformatf("rnd%0d_rdy", k), 1'b1);
            rand_rdy = 1'b1;
            gap_pct  = 30;
            send_frame(er);
            check_exp($sformatf("rnd%0d_bp", k), 1'b1);
        end
        rand_rdy = 1'b0;
        gap_pct  = 0;
        repeat (3) @(posedge clk);
        #1;

        // SOF in the middle of a frame restarts the frame at (0,0).
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) img[y][x] = ($urandom_range(0, 99) < 85);
        erode_en = 1'b1;
        for (int i = 0; i < 13; i++)
            send({DW{img[i/W][i%W]}}, i == 0, (i % W) == W-1);
        wait_out(13);
        base = outq.size();
        chk("pre_restart_frame_err", frame_err, 0);
        send_frame(1'b1);
        build_model(1'b1);
        check_exp("restart", 1'b1);
        chk("restart_frame_err", frame_err, 1);
        pulse_clr();
        chk("restart_clr", frame_err, 0);

        // Short line 2 (tlast at x=5): line_err set, next beat is (0,3).
        for (int y = 0; y < H; y++) for (int x = 0; x < W; x++) img[y][x] = 1'b1;
        expq.delete();
        erode_en = 1'b1;
        for (int y = 0; y < H; y++) begin
            int len;
            len = (y == 2) ? 6 : W;
            for (int x = 0; x < len; x++) begin
                send({DW{1'b1}}, x == 0 && y == 0, x == len-1);
                expq.push_back({1'(x == 0 && y == 0), 1'(x == len-1), {DW{1'(x >= 2 && y >= 2)}}});
            end
            if (y == 1) chk("lerr_before", line_err, 0);
            if (y == 2) chk("lerr_set", line_err, 1);
        end
        check_exp("short_line", 1'b1);
        chk("lerr_sticky", line_err, 1);

        // Extra beat after a complete frame: discarded, frame_err set.
        send({DW{1'b1}}, 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        chk("stray_no_out", outq.size(), base);
        chk("stray_frame_err", frame_err, 1);
        pulse_clr();
        chk("clr_line_err", line_err, 0);
        chk("clr_frame_err", frame_err, 0);

        // Reset in the middle of a frame, then a clean frame.
        erode_en = 1'b1;
        for (int i = 0; i < 20; i++) send({DW{1'b1}}, i == 0, (i % W) == W-1);
        aresetn = 1'b0;
        #1;
        chk("midrst_tvalid", m_axis_tvalid, 0);
        chk("midrst_tdata", m_axis_tdata, 0);
        chk("midrst_tready", s_axis_tready, 1);
        @(posedge clk);
        #1;
        aresetn = 1'b1;
        @(posedge clk);
        #1;
        base = outq.size();
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) img[y][x] = ($urandom_range(0, 99) < 80);
        send_frame(1'b1);
        build_model(1'b1);
        check_exp("after_rst", 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
